// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, with pipeline stall.
module ex_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quot_q, quot_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic                negQ_q, negQ_d;
  logic                negR_q, negR_d;

  logic                kill;
  logic                aSigned, bSigned, aNeg, bNeg;
  logic [XLEN-1:0]     aMag, bMag;
  logic                divByZero, divOvf;
  logic [XLEN-1:0]     addend;
  logic [XLEN:0]       mulSum;
  logic [XLEN:0]       partial, trial;
  logic                fits;
  logic [2*XLEN-1:0]   prodSigned;
  logic [XLEN-1:0]     quotSigned, remSigned, finalVal;

  // Operand decode: signedness per funct3, magnitudes and special divide cases.
  always_comb begin
    kill      = rst | flush;
    aSigned   = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    bSigned   = op[2] ? ~op[0] : ~op[1];
    aNeg      = aSigned & rs1[XLEN-1];
    bNeg      = bSigned & rs2[XLEN-1];
    aMag      = aNeg ? (~rs1 + 1'b1) : rs1;
    bMag      = bNeg ? (~rs2 + 1'b1) : rs2;
    divByZero = op[2] & (rs2 == '0);
    divOvf    = op[2] & ~op[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
  end

  // One datapath step; trial[XLEN] is the borrow since partial < 2*divisor always.
  always_comb begin
    addend  = prod_q[0] ? b_q : '0;
    mulSum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    partial = {rem_q, quot_q[XLEN-1]};
    trial   = partial - {1'b0, b_q};
    fits    = ~trial[XLEN];
  end

  always_comb begin
    prodSigned = negQ_q ? (~prod_q + 1'b1) : prod_q;
    quotSigned = negQ_q ? (~quot_q + 1'b1) : quot_q;
    remSigned  = negR_q ? (~rem_q + 1'b1) : rem_q;
    if (op_q[2])
      finalVal = op_q[1] ? remSigned : quotSigned;
    else
      finalVal = (op_q[1:0] == 2'b00) ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    b_d          = b_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    prod_d       = prod_q;
    negQ_d       = negQ_q;
    negR_d       = negR_q;
    result_d     = result_q;
    stall        = 1'b0;
    result_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          stall   = 1'b1;
          op_d    = op;
          b_d     = bMag;
          prod_d  = {{XLEN{1'b0}}, aMag};
          quot_d  = aMag;
          rem_d   = '0;
          cnt_d   = '0;
          negQ_d  = aNeg ^ bNeg;
          negR_d  = aNeg;
          state_d = CALC;
          // Special cases preload the final quotient/remainder and skip CALC.
          if (divByZero) begin
            quot_d  = '1;
            rem_d   = rs1;
            negQ_d  = 1'b0;
            negR_d  = 1'b0;
            state_d = DONE;
          end else if (divOvf) begin
            quot_d  = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            negQ_d  = 1'b0;
            negR_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        stall = ~kill;
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          rem_d  = fits ? trial[XLEN-1:0] : partial[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], fits};
        end else begin
          prod_d = {mulSum, prod_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(ITER-1))
          state_d = DONE;
      end
      DONE: begin
        result_valid = ~kill;
        if (!kill)
          result_d = finalVal;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      op_d    = '0;
      b_d     = '0;
      rem_d   = '0;
      quot_d  = '0;
      prod_d  = '0;
      negQ_d  = 1'b0;
      negR_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      prod_q   <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      prod_q   <= prod_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      result_q <= result_d;
    end
  end

  assign result = (state_q == DONE) ? finalVal : result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed plan cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_seq;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        stall, result_valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  ex_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic isSpecial(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    int ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    pu = {32'h0, a} * {32'h0, b};
    ia = a;
    ib = b;
    case (o)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  return pu[63:32];
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib; return q;
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib; return q;
      end
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, hold start until DONE, then check latency, stall length and result.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] expRes;
    int expLat, lat, stallCnt;
    expRes   = refModel(o, a, b);
    expLat   = isSpecial(o, a, b) ? 1 : 33;
    lat      = -1;
    stallCnt = 0;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1; flush = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      if (result_valid) begin
        lat = n;
        break;
      end
      if (stall) stallCnt++;
    end
    checkOutput($sformatf("latency op=%0d", o), 32'(lat), 32'(expLat));
    checkOutput($sformatf("stallCycles op=%0d", o), 32'(stallCnt), 32'(expLat));
    if (lat >= 0) begin
      checkOutput($sformatf("result op=%0d a=%08h b=%08h", o, a, b), result, expRes);
      checkOutput("stallInDone", 32'(stall), 32'd0);
    end
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput("singlePulse", 32'(result_valid), 32'd0);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int valids, stalls;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetStall", 32'(stall), 32'd0);
    checkOutput("resetValid", 32'(result_valid), 32'd0);
    checkOutput("resetResult", result, 32'd0);
    @(negedge clk) rst = 1'b0;

    applyStimulus(MUL,    32'd7,         32'hFFFF_FFFD, 1'b0);
    applyStimulus(MULH,   32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(DIV,    32'hFFFF_FFF9, 32'd2,         1'b0);
    applyStimulus(REM,    32'hFFFF_FFF9, 32'd2,         1'b0);
    applyStimulus(DIVU,   32'd100,       32'd7,         1'b0);
    applyStimulus(REMU,   32'd100,       32'd7,         1'b0);
    applyStimulus(DIVU,   32'd5,         32'd0,         1'b0);
    applyStimulus(REM,    32'd5,         32'd0,         1'b0);
    applyStimulus(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush ten cycles into CALC; nothing may come out afterwards.
    @(negedge clk);
    op = MUL; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    #1 checkOutput("flushCycleStall", 32'(stall), 32'd0);
    @(negedge clk) flush = 1'b0;
    valids = 0; stalls = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (result_valid) valids++;
      if (stall) stalls++;
      @(negedge clk);
    end
    checkOutput("flushNoValid", 32'(valids), 32'd0);
    checkOutput("flushNoStall", 32'(stalls), 32'd0);
    applyStimulus(MUL, 32'd3, 32'd4, 1'b0);

    // Reset five cycles into CALC, then back-to-back ops with start held.
    @(negedge clk);
    op = DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1;
    checkOutput("midResetStall", 32'(stall), 32'd0);
    checkOutput("midResetValid", 32'(result_valid), 32'd0);
    checkOutput("midResetResult", result, 32'd0);
    applyStimulus(DIVU,  32'd9, 32'd3, 1'b1);
    applyStimulus(MULHU, 32'd2, 32'd3, 1'b0);

    for (int i = 0; i < 30; i++)
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Iterative sequencer for the RV32M multiply/divide operations in the EX stage. It accepts one M-extension operation from the EX pipeline register and computes it over 32 iterations with shift-add or restoring division. While it computes, it holds the pipeline through a stall output. It returns the 32-bit result in a one-cycle DONE window, and the EX/MEM register captures it there in place of the ALU result.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, iteration count in CALC; equals XLEN

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  valid M-extension op present in EX this cycle
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  32  operand A (post-forwarding)
rs2  input  32  operand B (post-forwarding)
flush  input  1  kill the in-flight op (branch/jump redirect)
stall  output  1  hold PC, IF/ID and ID/EX registers
result  output  32  operation result, valid when result_valid=1
result_valid  output  1  one-cycle strobe in DONE

Behaviour:
- Reset and flush:
  - On rst=1 at a clk edge: state=IDLE, counter=0, stall=0, result_valid=0, result=0.
  - All internal accumulators are cleared.
- States:
  - IDLE: if start=1 and flush=0:
    - latch op, |rs1| and |rs2| according to signedness, and the result-sign flag;
    - special division case -> DONE;
    - otherwise -> CALC with counter=0.
  - CALC: one iteration per cycle; counter increments; after counter==31 -> DONE.
    - CALC lasts exactly 32 cycles.
  - DONE: result_valid=1 for exactly one cycle -> IDLE. start is ignored in DONE, because it is the same instruction still sitting in EX.
- stall (combinational):
  - stall = (IDLE & start & ~flush) | CALC.
  - stall is 0 in DONE, so the pipeline advances at the end of DONE.
- Latency:
  - Normal op with start at cycle T: CALC spans T+1..T+32, DONE at T+33.
  - stall is high for 33 cycles (T..T+32).
  - Special division case: DONE at T+1; stall high for 1 cycle.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - Magnitudes are taken before iterating.
- Multiply:
  - 64-bit product register, shift-add over 32 iterations.
  - If the result sign is negative, the 64-bit result is two's-complement negated in DONE.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
- Divide:
  - Restoring division: 32-bit quotient and 33-bit partial remainder.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special division cases (no CALC):
  - rs2==0: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - These cases do not apply to multiplies.
- Result holding: result holds its last value outside DONE. Consumers sample it only when result_valid=1.
- flush priority:
  - flush=1 in any state -> IDLE at the next edge; result_valid=0 and stall=0 in that cycle.
  - flush in DONE suppresses result_valid.
  - flush overrides start in the same cycle.
- Reset mid-operation: identical to flush. No partial result is emitted.
- Counter: 5-bit, no wrap-around used; it is cleared on entering CALC.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at T:
  - stall=1 for T..T+32;
  - result_valid=1 only at T+33;
  - result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each takes 33-cycle latency.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. For each:
  - stall high 1 cycle;
  - result_valid at T+1.
- flush=1 at T+10 during CALC:
  - IDLE at T+11;
  - stall=0 from T+11;
  - no result_valid pulse for 40 cycles;
  - a new MUL 3*4 afterwards -> 12.
- rst=1 at T+5 mid-CALC:
  - all outputs 0 next cycle;
  - then back-to-back ops DIVU 9/3 followed by MULHU 2*3 (start held continuously, operands changed after DONE) -> 3 then 0, each with a single result_valid pulse.
